// File: rtl/rr_arb_pkg.sv
// Shared types, requester indices and 4:1 mux select encoding
// for the round-robin mux arbiter.
package rr_arb_pkg;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [1:0] IDX_A = 2'd0;
    localparam logic [1:0] IDX_B = 2'd1;
    localparam logic [1:0] IDX_C = 2'd2;
    localparam logic [1:0] IDX_D = 2'd3;

    // Legacy mux encoding: index bits appear swapped on the select lines
    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b10;
    localparam logic [1:0] SEL_C = 2'b01;
    localparam logic [1:0] SEL_D = 2'b11;

    function automatic logic [1:0] sel_encode(input logic [1:0] idx);
        logic [1:0] s;
        unique case (idx)
            IDX_A:   s = SEL_A;
            IDX_B:   s = SEL_B;
            IDX_C:   s = SEL_C;
            default: s = SEL_D;
        endcase
        return s;
    endfunction

    function automatic logic [1:0] sel_decode(input logic [1:0] sel);
        logic [1:0] i;
        unique case (sel)
            SEL_A:   i = IDX_A;
            SEL_B:   i = IDX_B;
            SEL_C:   i = IDX_C;
            default: i = IDX_D;
        endcase
        return i;
    endfunction

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Requester-side bundle of the 4:1 mux arbiter: requests and data in,
// grant, select, valid and muxed data out.
interface rr_mux4_arbiter_if #(
    parameter int DW = 1
);
    logic [3:0]      req;
    logic [4*DW-1:0] din;
    logic [3:0]      gnt;
    logic [1:0]      sel;
    logic            valid;
    logic [DW-1:0]   y;

    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  valid,
        input  y
    );

    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output valid,
        output y
    );
endinterface

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker: scans req from ptr+1 upward,
// wrapping, so the bit at ptr is considered last.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] winner,
    output logic       any
);
    always_comb begin
        winner = ptr;
        any    = |req;
        // Walk offsets from far to near so the nearest set bit wins
        for (int k = 4; k >= 1; k--) begin
            if (req[ptr + 2'(k)]) begin
                winner = ptr + 2'(k);
            end
        end
    end
endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin owner arbitration for a shared 4:1 mux.
// Define ARB_TIMEOUT_EN to force rotation after MAX_HOLD busy cycles.
module rr_mux4_arbiter #(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 8
) (
    input logic         clk,
    input logic         rst_n,
    rr_mux4_arbiter_if.slave bus
);
    import rr_arb_pkg::*;

    state_t     state, state_n;
    logic [3:0] gnt_q, gnt_n;
    logic [1:0] sel_q, sel_n;
    logic       valid_q, valid_n;
    logic [1:0] ptr_q, ptr_n;
    logic [1:0] winner;
    logic       any;
    logic       other;
    logic       expire;

    rr_pick4 u_pick (
        .req    (bus.req),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any)
    );

    assign other = |(bus.req & ~gnt_q);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    logic [CW-1:0] hold_q, hold_n;

    assign expire = (hold_q == HOLD_MAX) && other;
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_n = state;
        gnt_n   = gnt_q;
        sel_n   = sel_q;
        valid_n = valid_q;
        ptr_n   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        hold_n  = hold_q;
`endif
        unique case (state)
            IDLE: begin
                if (any) begin
                    state_n = BUSY;
                    gnt_n   = 4'b0001 << winner;
                    sel_n   = sel_encode(winner);
                    valid_n = 1'b1;
                    ptr_n   = winner;
`ifdef ARB_TIMEOUT_EN
                    hold_n  = '0;
`endif
                end
            end
            BUSY: begin
                if (!bus.req[ptr_q] || expire) begin
                    // Owner is last in the scan, so winner is a non-owner
                    if (other) begin
                        gnt_n   = 4'b0001 << winner;
                        sel_n   = sel_encode(winner);
                        ptr_n   = winner;
`ifdef ARB_TIMEOUT_EN
                        hold_n  = '0;
`endif
                    end else begin
                        state_n = IDLE;
                        gnt_n   = 4'b0000;
                        sel_n   = SEL_A;
                        valid_n = 1'b0;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_q != HOLD_MAX) begin
                    hold_n = hold_q + 1'b1;
                end
`endif
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= SEL_A;
            valid_q <= 1'b0;
            ptr_q   <= IDX_D;
        end else begin
            state   <= state_n;
            gnt_q   <= gnt_n;
            sel_q   <= sel_n;
            valid_q <= valid_n;
            ptr_q   <= ptr_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_n;
        end
    end
`endif

    assign bus.gnt   = gnt_q;
    assign bus.sel   = sel_q;
    assign bus.valid = valid_q;
    assign bus.y     = valid_q
                     ? bus.din[int'(sel_decode(sel_q))*DW +: DW]
                     : '0;

    a_hold_range: assert property (@(posedge clk)
        MAX_HOLD >= 2 && MAX_HOLD <= 255);
    a_onehot: assert property (@(posedge clk) $onehot0(gnt_q));
    a_valid: assert property (@(posedge clk) valid_q == |gnt_q);
    a_sel: assert property (@(posedge clk)
        valid_q ? (gnt_q == (4'b0001 << sel_decode(sel_q)))
                : (sel_q == SEL_A));
endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 data mux between four requesters (A=0, B=1, C=2, D=3).
- Each requester raises req and holds it for as long as it needs the mux.
- The block grants one owner at a time, drives the mux select in the team's existing 4:1 mux encoding, and presents the selected data with a valid flag.
- Sits in front of any shared single-output path that was previously steered by a manually driven 2-bit select.

Parameters:
- DW, 1: data width per requester.
- MAX_HOLD, 8: maximum consecutive grant cycles per owner. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- req  input  4  request per requester; bit0=A, bit1=B, bit2=C, bit3=D.
- din  input  4*DW  packed data; A at [DW-1:0], B next, then C, D at top.
- gnt  output  4  one-hot registered grant.
- sel  output  2  registered mux select in the existing encoding: A=2'b00, B=2'b10, C=2'b01, D=2'b11.
- valid  output  1  registered; 1 while a grant is held.
- y  output  DW  combinational; equals the selected din slice when valid=1, else all zeros.

Behaviour:
- Reset is synchronous and active-low. All actions below take effect on the rising edge of clk with rst_n=0.
  - gnt=4'b0000, sel=2'b00, valid=0, state=IDLE, last-owner pointer=3 (D), so A has top priority after reset.
  - y=0 because valid=0.
  - Reset mid-grant drops the grant at that edge, regardless of req.
- State IDLE:
  - If req!=0, pick the first set bit scanning from pointer+1 upward, wrapping modulo 4.
  - On the next edge: state=BUSY, gnt=one-hot(winner), sel=encode(winner), valid=1, pointer=winner.
  - Latency from req sampled to gnt is 1 cycle.
- State BUSY:
  - While req[owner]=1, hold gnt, sel and valid unchanged.
  - When req[owner]=0 at an edge, release at that edge.
    - If other req bits are set, grant the next winner at the same edge. Handoff is back-to-back with no idle cycle.
    - Otherwise go to IDLE with gnt=0 and valid=0.
  - Requests from non-owners never preempt the owner, except via the Optional Feature.
- Simultaneous events:
  - The owner drops req on the same edge another requester rises: the new requester is eligible at that edge.
  - The owner's own bit is lowest priority in the scan, so a re-raised request by the last owner is served last.
- y = din[idx*DW +: DW], where idx is the decoded owner. Muxing is combinational from the registered sel, so y tracks din changes in the same cycle.
- Invariants, checked by assertion:
  - gnt is zero or one-hot.
  - valid == |gnt.
  - sel is consistent with gnt.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro defined:
  - A hold counter of width $clog2(MAX_HOLD+1) clears on every new grant and increments each BUSY cycle.
  - When the counter reaches MAX_HOLD and another req bit is set, the owner is forcibly rotated to the next round-robin winner at that edge, even if req[owner]=1. The pointer updates to the new winner.
  - If no other requester is pending, the owner keeps the grant and the counter saturates at MAX_HOLD.
- Without the macro:
  - No counter is built and MAX_HOLD is ignored.
  - An owner holding req keeps the grant indefinitely.

Decomposition:
- Shared package rr_arb_pkg holds:
  - state typedef (IDLE, BUSY);
  - requester index constants IDX_A..IDX_D;
  - SEL_A=2'b00, SEL_B=2'b10, SEL_C=2'b01, SEL_D=2'b11;
  - encode/decode functions between index and sel.
- One sub-module, rr_pick4: purely combinational rotate-priority picker. Inputs are req[3:0] and ptr[1:0]; outputs are winner[1:0] and any.
- The top module holds the FSM, registers, optional counter and data mux.

Test Plan:
- Reset: rst_n=0 for 2 cycles with req=4'b1111 → gnt=0, sel=2'b00, valid=0, y=0. Release reset → next edge gnt=4'b0001, sel=2'b00.
- Single request: req=4'b0100 from IDLE, din C=1 (DW=1) → one cycle later gnt=4'b0100, sel=2'b01, valid=1, y=1. Drop req → next edge gnt=0, valid=0.
- Fairness: req=4'b1111 held; each owner drops its bit for 1 cycle after 2 cycles of grant → grant order A,B,C,D,A with sel 00,10,01,11,00 and no valid=0 gap.
- Non-preemption and handoff: A owns; B raises req; A keeps req 5 more cycles → gnt stays 0001. A drops req → same edge gnt=0010, sel=2'b10.
- Reset mid-grant: C owns; assert rst_n=0 for 1 cycle → gnt=0, valid=0. After release with req=4'b1111 → A granted first.
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): A and B hold req continuously → grant alternates A, B, A, B. Without the macro → A owns indefinitely.
